// File: rtl/i2c_codec_init_seq_if.sv
// i2c_codec_init_seq_if
// Handshake and command bus between the codec init sequencer, the I2C write
// engine and the audio top level. The sequencer uses the master modport.
interface i2c_codec_init_seq_if;
    logic        i_start;
    logic        i_i2c_finished;
    logic        o_i2c_start;
    logic [6:0]  o_addr;
    logic        o_rw;
    logic [15:0] o_reg_data;
    logic [2:0]  o_cmd_idx;
    logic        o_busy;
    logic        o_finished;
    logic        o_error;

    modport master (
        input  i_start,
        input  i_i2c_finished,
        output o_i2c_start,
        output o_addr,
        output o_rw,
        output o_reg_data,
        output o_cmd_idx,
        output o_busy,
        output o_finished,
        output o_error
    );

    modport slave (
        output i_start,
        output i_i2c_finished,
        input  o_i2c_start,
        input  o_addr,
        input  o_rw,
        input  o_reg_data,
        input  o_cmd_idx,
        input  o_busy,
        input  o_finished,
        input  o_error
    );
endinterface

// File: rtl/i2c_codec_init_seq.sv
// i2c_codec_init_seq
// Walks the fixed 7-word WM8731 configuration table, issuing one start pulse
// per word to the I2C write engine, waiting for its finished pulse and then
// idling GAP_CYCLES before the next word. Reports completion on o_finished.
// Optional macro I2C_INIT_TIMEOUT_EN: per-command timeout with MAX_RETRY
// reissues, then S_ERR / o_error. Without it S_WAIT waits indefinitely.
module i2c_codec_init_seq #(
    parameter logic [6:0]  I2C_ADDR       = 7'h1A,
    parameter int unsigned GAP_CYCLES     = 4
`ifdef I2C_INIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRY      = 3
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    i2c_codec_init_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0]       LAST_IDX = 3'd6;
    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

`ifdef I2C_INIT_TIMEOUT_EN
    localparam int unsigned        TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned        RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
`endif

    // WM8731 configuration table: {7-bit register address, 9-bit data}
    function automatic logic [15:0] cmd_word(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_word = 16'h1E00; // reset
            3'd1:    cmd_word = 16'h0815; // analogue path
            3'd2:    cmd_word = 16'h0A00; // digital path
            3'd3:    cmd_word = 16'h0C00; // power down off
            3'd4:    cmd_word = 16'h0E42; // format: master, I2S, 16-bit
            3'd5:    cmd_word = 16'h1019; // sampling
            3'd6:    cmd_word = 16'h1201; // active
            default: cmd_word = 16'h0000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      data_q, data_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             start_q, busy_q, fin_q;
`ifdef I2C_INIT_TIMEOUT_EN
    logic [TO_W-1:0]    to_q, to_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               err_q;
`endif

    // Next-state, command index/word and counter updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        gap_d   = gap_q;
`ifdef I2C_INIT_TIMEOUT_EN
        to_d    = to_q;
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.i_start) begin
                    idx_d   = '0;
                    data_d  = cmd_word(3'd0);
                    state_d = S_START;
`ifdef I2C_INIT_TIMEOUT_EN
                    retry_d = '0;
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef I2C_INIT_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            S_WAIT: begin
                if (bus.i_i2c_finished) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        data_d  = cmd_word(idx_q + 3'd1);
                        gap_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? S_START : S_GAP;
`ifdef I2C_INIT_TIMEOUT_EN
                        retry_d = '0;
`endif
                    end
                end
`ifdef I2C_INIT_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    // Reissue the same word; o_reg_data and idx stay put
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_ERR;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_START;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers; outputs decode the next state
    // so each one is a flop aligned with the state it reports
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef I2C_INIT_TIMEOUT_EN
            to_q    <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            start_q <= (state_d == S_START);
            busy_q  <= (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_GAP);
            fin_q   <= (state_d == S_DONE);
`ifdef I2C_INIT_TIMEOUT_EN
            to_q    <= to_d;
            retry_q <= retry_d;
            err_q   <= (state_d == S_ERR);
`endif
        end
    end

    assign bus.o_i2c_start = start_q;
    assign bus.o_addr      = I2C_ADDR;
    assign bus.o_rw        = 1'b0;
    assign bus.o_reg_data  = data_q;
    assign bus.o_cmd_idx   = idx_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_finished  = fin_q;
`ifdef I2C_INIT_TIMEOUT_EN
    assign bus.o_error     = err_q;
`else
    assign bus.o_error     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_codec_init_seq.sv
// tb_i2c_codec_init_seq
// Scoreboard bench: tasks push the expected command words, a negedge process
// pops one per o_i2c_start and also plays the I2C engine (finished 30 cycles
// after each start). A second instance with GAP_CYCLES=0 checks the zero gap.
// Timeout scenario is compiled in with I2C_INIT_TIMEOUT_EN.
module tb_i2c_codec_init_seq;
    localparam int unsigned GAP   = 4;
    localparam int          LAT   = 30;
    localparam int          BOUND = 3000;
`ifdef I2C_INIT_TIMEOUT_EN
    localparam int unsigned TO_CYC  = 50;
    localparam int unsigned RETRIES = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_codec_init_seq_if bus ();
    i2c_codec_init_seq_if bus0 ();

`ifdef I2C_INIT_TIMEOUT_EN
    i2c_codec_init_seq #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_CYC), .MAX_RETRY(RETRIES))
        dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`else
    i2c_codec_init_seq #(.GAP_CYCLES(GAP))
        dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`endif
    i2c_codec_init_seq #(.GAP_CYCLES(0))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));

    logic [15:0] words [7] = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00,
                               16'h0E42, 16'h1019, 16'h1201};

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] sb [$];
    bit          mon_en        = 1'b0;
    bit          inj_once      = 1'b0;
    int          silent_idx    = -1;
    int          inj_start_idx = -1;
    int          inj_gap_idx   = -1;
    int          stub_cnt      = 0;
    int          last_fin_cyc  = -100;
    int          start_count   = 0;
    bit          holding       = 1'b0;
    logic [15:0] held          = '0;

    // Scoreboard monitor plus I2C engine stub for the main instance
    always @(negedge clk) begin
        logic        f;
        logic [15:0] e;
        f = 1'b0;
        if (rst) begin
            holding = 1'b0;
        end else if (mon_en) begin
            if (bus.o_i2c_start) begin
                start_count++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_start: got idx=%0d data=%h, required no start", bus.o_cmd_idx, bus.o_reg_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.o_reg_data !== e)
                        $display("FAIL start_word: got %h, required %h", bus.o_reg_data, e);
                    else
                        n_pass++;
                end
                n_total++;
                if (bus.o_addr !== 7'h1A || bus.o_rw !== 1'b0)
                    $display("FAIL addr_rw: got %h/%b, required 1a/0", bus.o_addr, bus.o_rw);
                else
                    n_pass++;
                held    = bus.o_reg_data;
                holding = 1'b1;
            end else if (holding) begin
                n_total++;
                if (bus.o_reg_data !== held)
                    $display("FAIL data_stable: got %h, required %h", bus.o_reg_data, held);
                else
                    n_pass++;
            end
        end
        if (inj_once) begin
            f        = 1'b1;
            inj_once = 1'b0;
        end
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                f            = 1'b1;
                last_fin_cyc = cyc;
                holding      = 1'b0;
            end
        end
        if (!rst && bus.o_i2c_start) begin
            if (int'(bus.o_cmd_idx) != silent_idx) stub_cnt = LAT;
            if (int'(bus.o_cmd_idx) == inj_start_idx) f = 1'b1;
        end
        if (inj_gap_idx >= 0 && !rst && bus.o_busy && cyc == last_fin_cyc + 2 &&
            int'(bus.o_cmd_idx) == inj_gap_idx)
            f = 1'b1;
        bus.i_i2c_finished = f;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic push_all();
        for (int i = 0; i < 7; i++) sb.push_back(words[i]);
    endtask

    task automatic wait_done(output int rise, output bit ok);
        ok   = 1'b0;
        rise = -1;
        for (int i = 0; i < BOUND; i++) begin
            if (bus.o_finished) begin
                ok   = 1'b1;
                rise = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        bus.i_start         = 1'b0;
        bus0.i_start        = 1'b0;
        bus0.i_i2c_finished = 1'b0;
        mon_en              = 1'b1;
        tick(2);
        n_total++;
        if ({bus.o_i2c_start, bus.o_reg_data, bus.o_cmd_idx, bus.o_busy, bus.o_finished, bus.o_error} !== 22'h0)
            $display("FAIL reset_outputs: got %b%h%0d%b%b%b, required all zero", bus.o_i2c_start, bus.o_reg_data,
                     bus.o_cmd_idx, bus.o_busy, bus.o_finished, bus.o_error);
        else n_pass++;
        n_total++;
        if ({bus0.o_i2c_start, bus0.o_reg_data, bus0.o_cmd_idx, bus0.o_busy, bus0.o_finished, bus0.o_error} !== 22'h0)
            $display("FAIL reset_outputs_gap0: got data=%h idx=%0d busy=%b, required all zero", bus0.o_reg_data,
                     bus0.o_cmd_idx, bus0.o_busy);
        else n_pass++;
        n_total++;
        if (bus.o_addr !== 7'h1A || bus.o_rw !== 1'b0)
            $display("FAIL reset_addr_rw: got %h/%b, required 1a/0", bus.o_addr, bus.o_rw);
        else n_pass++;
        rst = 1'b0;
        tick(3);
        n_total++;
        if (bus.o_busy !== 1'b0 || bus.o_i2c_start !== 1'b0)
            $display("FAIL idle_no_start: got busy=%b start=%b, required 0/0", bus.o_busy, bus.o_i2c_start);
        else n_pass++;
    endtask

    task automatic test_nominal();
        int s0, rise;
        bit ok;
        sb.delete();
        push_all();
        s0 = start_count;
        pulse_start();
        wait_done(rise, ok);
        n_total++;
        if (!ok) $display("FAIL nominal_done: got no o_finished in %0d cycles, required done", BOUND);
        else n_pass++;
        n_total++;
        if (start_count - s0 != 7) $display("FAIL nominal_starts: got %0d, required 7", start_count - s0);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL nominal_sb_empty: got %0d left, required 0", sb.size());
        else n_pass++;
        n_total++;
        if (rise != last_fin_cyc + 1)
            $display("FAIL done_latency: got %0d, required %0d", rise - last_fin_cyc, 1);
        else n_pass++;
        n_total++;
        if (bus.o_busy !== 1'b0 || bus.o_cmd_idx !== 3'd6 || bus.o_error !== 1'b0)
            $display("FAIL done_state: got busy=%b idx=%0d err=%b, required 0/6/0", bus.o_busy, bus.o_cmd_idx, bus.o_error);
        else n_pass++;
    endtask

    task automatic test_gap_timing();
        int sc, gaps;
        sb.delete();
        push_all();
        pulse_start();
        sc   = cyc;
        gaps = 0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (bus.o_i2c_start && last_fin_cyc > sc) begin
                gaps++;
                n_total++;
                if (cyc - last_fin_cyc != int'(GAP) + 1)
                    $display("FAIL gap_timing: got %0d, required %0d", cyc - last_fin_cyc, GAP + 1);
                else n_pass++;
            end
            if (bus.o_finished) break;
        end
        n_total++;
        if (gaps != 6) $display("FAIL gap_count: got %0d, required 6", gaps);
        else n_pass++;
    endtask

    task automatic test_gap_zero();
        logic [15:0] q0 [$];
        logic [15:0] e;
        int cnt, tfin, nst;
        bit ok;
        for (int i = 0; i < 7; i++) q0.push_back(words[i]);
        cnt  = 0;
        tfin = -100;
        nst  = 0;
        ok   = 1'b0;
        bus0.i_start = 1'b1;
        tick();
        bus0.i_start = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            bus0.i_i2c_finished = 1'b0;
            if (bus0.o_finished) begin
                ok = 1'b1;
                break;
            end
            if (bus0.o_i2c_start) begin
                nst++;
                e = (q0.size() != 0) ? q0.pop_front() : 16'hxxxx;
                n_total++;
                if (bus0.o_reg_data !== e) $display("FAIL gap0_word: got %h, required %h", bus0.o_reg_data, e);
                else n_pass++;
                if (tfin >= 0) begin
                    n_total++;
                    if (cyc - tfin != 1) $display("FAIL gap0_timing: got %0d, required 1", cyc - tfin);
                    else n_pass++;
                end
                cnt = 4;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus0.i_i2c_finished = 1'b1;
                    tfin = cyc;
                end
            end
            tick();
        end
        n_total++;
        if (!ok || nst != 7) $display("FAIL gap0_sequence: got done=%b starts=%0d, required 1/7", ok, nst);
        else n_pass++;
    endtask

    task automatic test_spurious();
        int s0, hold;
        bit chk_next, ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        inj_once = 1'b1;
        tick(3);
        n_total++;
        if (bus.o_cmd_idx !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_i2c_start !== 1'b0)
            $display("FAIL idle_finished_ignored: got idx=%0d busy=%b, required 0/0", bus.o_cmd_idx, bus.o_busy);
        else n_pass++;
        sb.delete();
        push_all();
        inj_start_idx = 1;
        inj_gap_idx   = 3;
        s0            = start_count;
        hold          = 0;
        chk_next      = 1'b0;
        ok            = 1'b0;
        pulse_start();
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (chk_next) begin
                chk_next = 1'b0;
                n_total++;
                if (bus.o_cmd_idx !== 3'd1) $display("FAIL start_cycle_finished: got idx=%0d, required 1", bus.o_cmd_idx);
                else n_pass++;
            end
            if (bus.o_i2c_start && bus.o_cmd_idx == 3'd1) chk_next = 1'b1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) bus.i_start = 1'b0;
            end
            if (bus.o_i2c_start && bus.o_cmd_idx == 3'd3) begin
                bus.i_start = 1'b1;
                hold        = 10;
            end
            if (bus.o_finished) begin
                ok = 1'b1;
                break;
            end
        end
        bus.i_start   = 1'b0;
        inj_start_idx = -1;
        inj_gap_idx   = -1;
        n_total++;
        if (!ok || start_count - s0 != 7 || sb.size() != 0)
            $display("FAIL spurious_sequence: got done=%b starts=%0d left=%0d, required 1/7/0", ok, start_count - s0, sb.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int s0, rise;
        bit ok;
        sb.delete();
        for (int i = 0; i < 4; i++) sb.push_back(words[i]);
        s0 = start_count;
        pulse_start();
        for (int i = 0; i < BOUND; i++) begin
            if (bus.o_i2c_start && bus.o_cmd_idx == 3'd3) break;
            tick();
        end
        tick(5);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.o_i2c_start, bus.o_reg_data, bus.o_cmd_idx, bus.o_busy, bus.o_finished, bus.o_error} !== 22'h0)
            $display("FAIL async_reset: got data=%h idx=%0d busy=%b start=%b, required all zero", bus.o_reg_data,
                     bus.o_cmd_idx, bus.o_busy, bus.o_i2c_start);
        else n_pass++;
        tick(2);
        #2 rst = 1'b0;
        tick(LAT + 10);
        n_total++;
        if (bus.o_busy !== 1'b0 || bus.o_cmd_idx !== 3'd0 || bus.o_finished !== 1'b0 || start_count - s0 != 4)
            $display("FAIL late_finished_ignored: got busy=%b idx=%0d starts=%0d, required 0/0/4", bus.o_busy,
                     bus.o_cmd_idx, start_count - s0);
        else n_pass++;
        push_all();
        s0 = start_count;
        pulse_start();
        wait_done(rise, ok);
        n_total++;
        if (!ok || start_count - s0 != 7 || sb.size() != 0)
            $display("FAIL reset_restart: got done=%b starts=%0d left=%0d, required 1/7/0", ok, start_count - s0, sb.size());
        else n_pass++;
    endtask

    task automatic test_restart_done();
        int s0, rise;
        bit ok;
        sb.delete();
        push_all();
        s0 = start_count;
        pulse_start();
        n_total++;
        if (bus.o_finished !== 1'b0 || bus.o_i2c_start !== 1'b1)
            $display("FAIL restart_drop: got fin=%b start=%b, required 0/1", bus.o_finished, bus.o_i2c_start);
        else n_pass++;
        wait_done(rise, ok);
        n_total++;
        if (!ok || start_count - s0 != 7 || sb.size() != 0)
            $display("FAIL restart_sequence: got done=%b starts=%0d left=%0d, required 1/7/0", ok, start_count - s0, sb.size());
        else n_pass++;
    endtask

`ifdef I2C_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int prev, n2, s0, rise;
        bit ok;
        sb.delete();
        sb.push_back(words[0]);
        sb.push_back(words[1]);
        for (int i = 0; i <= int'(RETRIES); i++) sb.push_back(words[2]);
        silent_idx = 2;
        prev       = -1;
        n2         = 0;
        ok         = 1'b0;
        pulse_start();
        for (int i = 0; i < BOUND; i++) begin
            tick();
            if (bus.o_i2c_start && bus.o_cmd_idx == 3'd2) begin
                if (n2 > 0) begin
                    n_total++;
                    if (cyc - prev != int'(TO_CYC) + 1)
                        $display("FAIL retry_spacing: got %0d, required %0d", cyc - prev, TO_CYC + 1);
                    else n_pass++;
                end
                prev = cyc;
                n2++;
            end
            if (bus.o_error) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (!ok || n2 != int'(RETRIES) + 1 || cyc - prev != int'(TO_CYC) + 1)
            $display("FAIL timeout_error: got err=%b starts=%0d delay=%0d, required 1/%0d/%0d", ok, n2, cyc - prev,
                     RETRIES + 1, TO_CYC + 1);
        else n_pass++;
        n_total++;
        if (bus.o_cmd_idx !== 3'd2 || bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0)
            $display("FAIL error_state: got idx=%0d busy=%b fin=%b, required 2/0/0", bus.o_cmd_idx, bus.o_busy, bus.o_finished);
        else n_pass++;
        silent_idx = -1;
        push_all();
        s0 = start_count;
        pulse_start();
        n_total++;
        if (bus.o_error !== 1'b0) $display("FAIL error_clear: got %b, required 0", bus.o_error);
        else n_pass++;
        wait_done(rise, ok);
        n_total++;
        if (!ok || start_count - s0 != 7 || sb.size() != 0)
            $display("FAIL error_restart: got done=%b starts=%0d left=%0d, required 1/7/0", ok, start_count - s0, sb.size());
        else n_pass++;
    endtask
`endif

    initial begin
        rst                 = 1'b1;
        bus.i_start         = 1'b0;
        bus0.i_start        = 1'b0;
        bus0.i_i2c_finished = 1'b0;
        test_reset();
        test_nominal();
        test_gap_timing();
        test_gap_zero();
        test_spurious();
        test_mid_reset();
        test_restart_done();
`ifdef I2C_INIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/i2c_codec_init_seq.md
Name: i2c_codec_init_seq

Overview:
- Upstream sequencer for the I2C write engine.
- After a trigger, walks a fixed table of 7 WM8731 configuration words (7-bit register address + 9-bit data).
- For each word it issues one start pulse to the I2C engine, waits for the engine's finished pulse, then inserts an idle gap before the next word.
- Reports completion to the audio top level, which holds off the recorder/player until the codec is configured.

Parameters:
- I2C_ADDR, 7'h1A, codec slave address driven on o_addr.
- GAP_CYCLES, 4, idle cycles between one finished pulse and the next start pulse (0 allowed).
- TIMEOUT_CYCLES, 1024, cycles waited for finished before retry (used only with the optional feature).
- MAX_RETRY, 3, retries per command before error (used only with the optional feature).

Ports:
- i_clk  in  1  system clock, the same clock as the I2C engine.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- i_start  in  1  level, sampled in S_IDLE/S_DONE/S_ERR; begins the sequence.
- i_i2c_finished  in  1  one-cycle pulse from the I2C engine at end of its STOP.
- o_i2c_start  out  1  one-cycle start pulse to the I2C engine.
- o_addr  out  7  slave address; constant I2C_ADDR.
- o_rw  out  1  constant 0 (write).
- o_reg_data  out  16  current command word, registered.
- o_cmd_idx  out  3  index of the current command, 0..6.
- o_busy  out  1  high in S_START/S_WAIT/S_GAP.
- o_finished  out  1  level, high in S_DONE.
- o_error  out  1  level, high in S_ERR; tied 0 without the optional feature.

Behaviour:
- Command table, index 0..6: 16'h1E00 (reset), 16'h0815 (analogue path), 16'h0A00 (digital path), 16'h0C00 (power down off), 16'h0E42 (format: master, I2S, 16-bit), 16'h1019 (sampling), 16'h1201 (active).
- States: S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_ERR. All outputs are registered.
- Reset values: state S_IDLE, o_i2c_start=0, o_reg_data=16'h0000, o_cmd_idx=0, o_busy=0, o_finished=0, o_error=0, all internal counters 0.
- Reset is asynchronous and may arrive mid-sequence. Outputs clear immediately. A finished pulse arriving afterwards in S_IDLE is ignored.
- S_IDLE: if i_start=1, load idx=0 and o_reg_data=table[0], then go to S_START. o_i2c_start rises in the cycle after i_start is sampled.
- S_START: o_i2c_start=1 for exactly one cycle, then go to S_WAIT. i_i2c_finished in this state is ignored.
- S_WAIT: hold o_reg_data stable. The I2C engine reads it combinationally throughout the transfer, so it must not change before finished.
  - On i_i2c_finished=1 with idx==6: go to S_DONE.
  - On i_i2c_finished=1 otherwise: idx+1, load the next table word, go to S_GAP. With GAP_CYCLES=0, go directly to S_START.
- S_GAP: count GAP_CYCLES cycles, then go to S_START. The next o_i2c_start is high exactly GAP_CYCLES+1 cycles after the cycle in which finished was high.
- S_DONE: o_finished=1, o_busy=0. i_start=1 restarts from idx 0 (o_finished drops next cycle).
- i_start while busy is ignored. A finished pulse outside S_WAIT is ignored.
- Minimum-length sequence: 7 start pulses, 7 finished pulses. o_finished rises the cycle after the 7th finished pulse.

Optional Feature:
- Macro I2C_INIT_TIMEOUT_EN.
- When defined:
  - S_WAIT runs a timeout counter, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without finished, the same command is reissued via S_START and the retry count increments. The retry count resets to 0 on advance to the next command.
  - A timeout when the retry count already equals MAX_RETRY goes to S_ERR: o_error=1, o_busy=0, o_cmd_idx frozen at the failing index.
  - S_ERR holds until i_start=1, which restarts from idx 0 and clears o_error.
- When not defined: S_WAIT waits indefinitely, S_ERR is unreachable, o_error is constant 0, and no timeout/retry logic is synthesized.

Test Plan:
- Nominal: reset, pulse i_start; I2C stub returns finished 30 cycles after each start. Required: 7 start pulses carrying o_reg_data 1E00, 0815, 0A00, 0C00, 0E42, 1019, 1201 in order. o_addr=7'h1A, o_rw=0 throughout. o_finished rises 1 cycle after the 7th finished pulse.
- Gap timing: GAP_CYCLES=4, finished at cycle T. Required: next o_i2c_start at T+5. Repeat with GAP_CYCLES=0: next o_i2c_start at T+1.
- Stability and spurious inputs:
  - o_reg_data must stay unchanged every cycle between a start pulse and its finished.
  - An extra finished pulse injected in S_IDLE, in S_GAP, or in the cycle of o_i2c_start must not advance o_cmd_idx.
  - i_start held high during S_WAIT must not restart the sequence.
- Mid-operation reset: assert i_rst during command 3 in S_WAIT. Required: all outputs reach reset values immediately. A later finished pulse is ignored. A new i_start restarts with 1E00.
- Restart from done: pulse i_start in S_DONE. Required: o_finished=0 next cycle, and the full 7-command sequence repeats.
- Timeout (I2C_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=50, MAX_RETRY=3): stub never answers command 2. Required: 4 start pulses with 0A00 spaced by timeout windows, then o_error=1 with o_cmd_idx=2. i_start clears o_error and restarts at 1E00.
